// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the 1-D systolic array sequencer.
package sa_pkg;

  localparam int PSUM_W   = 16;
  localparam int NUM_TAPS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sa_out_fifo.sv
// Small synchronous FIFO that buffers array results ({last, psum}) for the output stream.
module sa_out_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sa_1d_ctrl.sv
// Sequencer for the 3-tap systolic convolution array: buffers a frame, issues skewed
// windows under output-FIFO credit, and streams results with frame-last marking.
module sa_1d_ctrl
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_LEN     = 64,
  parameter int LEN_W       = 7,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_w0,
  input  logic [DATA_WIDTH-1:0] cfg_w1,
  input  logic [DATA_WIDTH-1:0] cfg_w2,
  output logic                  err_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  sa_valid_in,
  output logic [DATA_WIDTH-1:0] sa_data_in0,
  output logic [DATA_WIDTH-1:0] sa_data_in1,
  output logic [DATA_WIDTH-1:0] sa_data_in2,
  output logic [DATA_WIDTH-1:0] sa_weight_in0,
  output logic [DATA_WIDTH-1:0] sa_weight_in1,
  output logic [DATA_WIDTH-1:0] sa_weight_in2,
  output logic [PSUM_W-1:0]     sa_psum_in,
  input  logic                  sa_valid_out,
  input  logic [PSUM_W-1:0]     sa_psum_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PSUM_W-1:0]     m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W  = $clog2(OFIFO_DEPTH + 1);
  localparam int SUM_W  = CNT_W + 2;
  localparam int FIFO_W = PSUM_W + 1;

  state_t                state;
  state_t                next_state;
  logic [LEN_W-1:0]      len_q;
  logic [IDX_W-1:0]      wr_ptr;
  logic [IDX_W-1:0]      iss_idx;
  logic [IDX_W-1:0]      ret_idx;
  logic                  s1_valid;
  logic                  s2_valid;
  logic [IDX_W-1:0]      s1_idx;
  logic [IDX_W-1:0]      s2_idx;
  logic [IDX_W-1:0]      rd1_idx;
  logic [IDX_W-1:0]      rd2_idx;
  logic [1:0]            inflight;
  logic                  last_popped;
  logic [DATA_WIDTH-1:0] frame_buf [MAX_LEN];

  logic                  cfg_fire;
  logic                  len_legal;
  logic                  load_fire;
  logic                  load_done;
  logic                  issue;
  logic                  credit_ok;
  logic                  last_issue;
  logic                  ret_fire;
  logic                  ret_last;
  logic [LEN_W-1:0]      last_idx;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [FIFO_W-1:0]     fifo_wdata;
  logic [FIFO_W-1:0]     fifo_rdata;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign len_legal  = (cfg_len >= LEN_W'(NUM_TAPS)) && (cfg_len <= LEN_W'(MAX_LEN));
  assign load_fire  = s_valid && s_ready;
  assign load_done  = load_fire && (LEN_W'(wr_ptr) == len_q - LEN_W'(1));
  assign last_idx   = len_q - LEN_W'(NUM_TAPS);
  assign last_issue = issue && (LEN_W'(iss_idx) == last_idx);
  // A window may start only if its result is guaranteed a FIFO slot when it returns.
  assign credit_ok  = (SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(OFIFO_DEPTH);
  // Returns with nothing in flight are leftovers from before a reset and are dropped.
  assign ret_fire   = sa_valid_out && (inflight != 2'd0);
  assign ret_last   = (LEN_W'(ret_idx) == last_idx);
  assign fifo_push  = ret_fire && (!fifo_full || fifo_pop);
  assign fifo_wdata = {ret_last, sa_psum_out};
  assign fifo_pop   = m_valid && m_ready;

  assign sa_valid_in = issue;
  assign sa_psum_in  = '0;
  assign m_valid     = !fifo_empty;
  assign m_data      = m_valid ? fifo_rdata[PSUM_W-1:0] : '0;
  assign m_last      = m_valid && fifo_rdata[PSUM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_fire && len_legal) next_state = LOAD;
      LOAD:    if (load_done) next_state = RUN;
      RUN:     if (last_issue) next_state = DRAIN;
      DRAIN:   if ((inflight == 2'd0) && fifo_empty && last_popped) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD:    s_ready = 1'b1;
      RUN:     issue   = credit_ok;
      default: ;
    endcase
  end

  // Later taps see the same window one and two cycles after issue, matching the PE chain.
  always_comb begin
    rd1_idx     = s1_idx + IDX_W'(1);
    rd2_idx     = s2_idx + IDX_W'(2);
    sa_data_in0 = issue    ? frame_buf[iss_idx] : '0;
    sa_data_in1 = s1_valid ? frame_buf[rd1_idx] : '0;
    sa_data_in2 = s2_valid ? frame_buf[rd2_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      frame_buf[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= '0;
      sa_weight_in0 <= '0;
      sa_weight_in1 <= '0;
      sa_weight_in2 <= '0;
      err_len       <= 1'b0;
      wr_ptr        <= '0;
      iss_idx       <= '0;
      ret_idx       <= '0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s1_idx        <= '0;
      s2_idx        <= '0;
      inflight      <= 2'd0;
      last_popped   <= 1'b0;
    end else begin
      err_len <= cfg_fire && !len_legal;
      if (cfg_fire && len_legal) begin
        len_q         <= cfg_len;
        sa_weight_in0 <= cfg_w0;
        sa_weight_in1 <= cfg_w1;
        sa_weight_in2 <= cfg_w2;
        wr_ptr        <= '0;
        iss_idx       <= '0;
        ret_idx       <= '0;
        last_popped   <= 1'b0;
      end
      if (load_fire) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
      end
      if (issue) begin
        iss_idx <= iss_idx + IDX_W'(1);
      end
      if (ret_fire) begin
        ret_idx <= ret_idx + IDX_W'(1);
      end
      s1_valid <= issue;
      s1_idx   <= iss_idx;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      case ({issue, ret_fire})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
      if (fifo_pop && fifo_rdata[PSUM_W]) begin
        last_popped <= 1'b1;
      end
    end
  end

  sa_out_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (OFIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sa_1d_ctrl.sv
// Self-checking bench for sa_1d_ctrl: emulates the 3-PE array and scores the output stream
// against convolution results computed directly from the frame samples and weights.
module tb_sa_1d_ctrl;

  localparam int DW      = 8;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int DEPTH   = 4;
  localparam int PW      = 16;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic [DW-1:0]    cfg_w0, cfg_w1, cfg_w2;
  logic             err_len;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic             sa_valid_in;
  logic [DW-1:0]    sa_data_in0, sa_data_in1, sa_data_in2;
  logic [DW-1:0]    sa_weight_in0, sa_weight_in1, sa_weight_in2;
  logic [PW-1:0]    sa_psum_in;
  logic             sa_valid_out;
  logic [PW-1:0]    sa_psum_out;
  logic             m_valid;
  logic             m_ready;
  logic [PW-1:0]    m_data;
  logic             m_last;
  logic             busy;

  typedef struct packed {
    logic          last;
    logic [PW-1:0] data;
  } res_t;

  res_t          exp_q [$];
  res_t          pop_log [$];
  res_t          exp_item;
  logic [DW-1:0] x_arr [MAX_LEN];
  int            assert_count = 0;
  int            fail_count   = 0;
  int            issue_cnt    = 0;
  int            pop_cnt      = 0;
  int            max_out      = 0;
  int            err_cnt      = 0;
  int            ready_mode   = 0;

  sa_1d_ctrl #(
    .DATA_WIDTH  (DW),
    .MAX_LEN     (MAX_LEN),
    .LEN_W       (LEN_W),
    .OFIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_len       (cfg_len),
    .cfg_w0        (cfg_w0),
    .cfg_w1        (cfg_w1),
    .cfg_w2        (cfg_w2),
    .err_len       (err_len),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .sa_valid_in   (sa_valid_in),
    .sa_data_in0   (sa_data_in0),
    .sa_data_in1   (sa_data_in1),
    .sa_data_in2   (sa_data_in2),
    .sa_weight_in0 (sa_weight_in0),
    .sa_weight_in1 (sa_weight_in1),
    .sa_weight_in2 (sa_weight_in2),
    .sa_psum_in    (sa_psum_in),
    .sa_valid_out  (sa_valid_out),
    .sa_psum_out   (sa_psum_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stand-in: each PE consumes its inputs on the cycle valid reaches it; result at T+3.
  logic          a_v1, a_v2, a_v3;
  logic [PW-1:0] a_p1, a_p2, a_p3;

  function automatic logic [PW-1:0] mul8(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {8'd0, a} * {8'd0, b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1 <= 1'b0; a_v2 <= 1'b0; a_v3 <= 1'b0;
      a_p1 <= '0;   a_p2 <= '0;   a_p3 <= '0;
    end else begin
      a_v1 <= sa_valid_in;
      a_p1 <= sa_psum_in + mul8(sa_weight_in0, sa_data_in0);
      a_v2 <= a_v1;
      a_p2 <= a_p1 + mul8(sa_weight_in1, sa_data_in1);
      a_v3 <= a_v2;
      a_p3 <= a_p2 + mul8(sa_weight_in2, sa_data_in2);
    end
  end

  assign sa_valid_out = a_v3;
  assign sa_psum_out  = a_p3;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Output-side monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len) err_cnt++;
      if (sa_valid_in) issue_cnt++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        pop_log.push_back({m_last, m_data});
        checkOutput("result_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          checkOutput("result_data", 32'(m_data), 32'(exp_item.data));
          checkOutput("result_last", 32'(m_last), 32'(exp_item.last));
        end
      end
      if (issue_cnt - pop_cnt > max_out) max_out = issue_cnt - pop_cnt;
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
    checkOutput({tag, "_outputs_zero"},
                32'(|{err_len, s_ready, sa_valid_in, sa_data_in0, sa_data_in1, sa_data_in2,
                      sa_weight_in0, sa_weight_in1, sa_weight_in2, sa_psum_in,
                      m_valid, m_data, m_last, busy}), 0);
  endtask

  task automatic sendCfg(input int len, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
    int t;
    cfg_valid = 1'b1;
    cfg_len   = LEN_W'(len);
    cfg_w0    = a;
    cfg_w1    = b;
    cfg_w2    = c;
    t = 0;
    while (!cfg_ready && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("cfg_ready_wait", 32'(cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Queues the expected results for x_arr[0..len-1], then configures and loads the frame.
  task automatic applyStimulus(input int len, input int gap_pct, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW-1:0] c);
    int   y;
    int   t;
    res_t item;
    for (int n = 0; n <= len - 3; n++) begin
      y = int'(a) * int'(x_arr[n]) + int'(b) * int'(x_arr[n+1]) + int'(c) * int'(x_arr[n+2]);
      item.data = PW'(y % 65536);
      item.last = (n == len - 3);
      exp_q.push_back(item);
    end
    sendCfg(len, a, b, c);
    for (int i = 0; i < len; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = x_arr[i];
      t = 0;
      while (!s_ready && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!s_ready) checkOutput("s_ready_wait", 32'(s_ready), 1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput({tag, "_drained"}, 32'(exp_q.size()), 0);
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic randomFrame(input int len);
    for (int i = 0; i < len; i++) x_arr[i] = DW'($urandom);
  endtask

  initial begin
    int t;
    int lat;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    cfg_w0    = '0;
    cfg_w1    = '0;
    cfg_w2    = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic frame");
    for (int i = 0; i < 5; i++) x_arr[i] = DW'(i + 1);
    pop_log.delete();
    ready_mode = 0;
    applyStimulus(5, 0, 8'd1, 8'd2, 8'd3);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sa_valid_in && t < 20);
    checkOutput("basic_first_issue", 32'(sa_valid_in), 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid && lat < 20);
    checkOutput("basic_first_latency", 32'(lat), 4);
    @(posedge clk);
    #1;
    waitIdle("basic");
    checkOutput("basic_count", 32'(pop_log.size()), 3);
    if (pop_log.size() == 3) begin
      checkOutput("basic_y0", 32'(pop_log[0]), 32'({1'b0, 16'd14}));
      checkOutput("basic_y1", 32'(pop_log[1]), 32'({1'b0, 16'd20}));
      checkOutput("basic_y2", 32'(pop_log[2]), 32'({1'b1, 16'd26}));
    end

    $display("[TB] illegal lengths");
    err_cnt = 0;
    sendCfg(2, 8'd1, 8'd1, 8'd1);
    checkOutput("len2_err_pulse", 32'(err_len), 1);
    checkOutput("len2_cfg_ready", 32'(cfg_ready), 1);
    checkOutput("len2_busy", 32'(busy), 0);
    checkOutput("len2_s_ready", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("len2_err_clear", 32'(err_len), 0);
    sendCfg(65, 8'd1, 8'd1, 8'd1);
    checkOutput("len65_err_pulse", 32'(err_len), 1);
    checkOutput("len65_busy", 32'(busy), 0);
    checkOutput("len65_s_ready", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("err_pulse_count", 32'(err_cnt), 2);
    checkOutput("illegal_cfg_ready", 32'(cfg_ready), 1);

    $display("[TB] wrap-around");
    for (int i = 0; i < 3; i++) x_arr[i] = 8'd255;
    pop_log.delete();
    applyStimulus(3, 0, 8'd255, 8'd255, 8'd255);
    waitIdle("wrap");
    checkOutput("wrap_count", 32'(pop_log.size()), 1);
    if (pop_log.size() == 1) checkOutput("wrap_y0", 32'(pop_log[0]), 32'({1'b1, 16'd64003}));

    $display("[TB] backpressure");
    randomFrame(10);
    ready_mode = 2;
    issue_cnt  = 0;
    pop_cnt    = 0;
    max_out    = 0;
    applyStimulus(10, 0, DW'($urandom), DW'($urandom), DW'($urandom));
    repeat (20) @(posedge clk);
    #1;
    checkOutput("bp_issue_stall", 32'(issue_cnt), 4);
    checkOutput("bp_m_valid", 32'(m_valid), 1);
    checkOutput("bp_no_pops", 32'(pop_cnt), 0);
    ready_mode = 0;
    waitIdle("bp");
    checkOutput("bp_result_count", 32'(pop_cnt), 8);
    checkOutput("bp_max_outstanding", 32'(max_out), 4);

    $display("[TB] reset mid-frame");
    randomFrame(10);
    ready_mode = 2;
    issue_cnt  = 0;
    applyStimulus(10, 0, DW'($urandom), DW'($urandom), DW'($urandom));
    t = 0;
    while (issue_cnt < 2 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("midrun_two_issued", 32'(issue_cnt), 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkResetState("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    checkResetState("midrun_reset_hold");
    rst_n      = 1'b1;
    issue_cnt  = 0;
    pop_cnt    = 0;
    max_out    = 0;
    ready_mode = 1;
    @(posedge clk);
    #1;
    randomFrame(4);
    applyStimulus(4, 20, DW'($urandom), DW'($urandom), DW'($urandom));
    waitIdle("after_reset");
    checkOutput("after_reset_count", 32'(pop_cnt), 2);

    $display("[TB] back-to-back frames");
    pop_cnt = 0;
    randomFrame(6);
    applyStimulus(6, 0, DW'($urandom), DW'($urandom), DW'($urandom));
    randomFrame(7);
    applyStimulus(7, 40, DW'($urandom), DW'($urandom), DW'($urandom));
    waitIdle("b2b");
    checkOutput("b2b_count", 32'(pop_cnt), 9);

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      int len;
      len = (k == 3) ? MAX_LEN : int'($urandom_range(3, 20));
      pop_cnt = 0;
      randomFrame(len);
      applyStimulus(len, 25, DW'($urandom), DW'($urandom), DW'($urandom));
      waitIdle("rand");
      checkOutput("rand_count", 32'(pop_cnt), 32'(len - 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
